// File: rtl/int_ctrl.sv
// Prioritised 8-source interrupt controller with PC redirect at writeback.
// Optional nesting (two active handlers) enabled by defining INT_NEST_EN.
module int_ctrl #(
    parameter int              N_SRC      = 8,
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = 16'h0100,
    parameter int              VEC_STRIDE = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_SRC-1:0]  IRQ_IN,
    input  logic              WB_STROBE,
    input  logic [ADDR_W-1:0] PC_IN,
    input  logic              RETI,
    input  logic              GIE_WE,
    input  logic              GIE_D,
    input  logic              MASK_WE,
    input  logic [N_SRC-1:0]  MASK_D,
    output logic [N_SRC-1:0]  MASK,
    output logic [N_SRC-1:0]  PENDING,
    output logic              INT_TAKE,
    output logic [ADDR_W-1:0] INT_VEC,
    output logic [2:0]        INT_ID,
    output logic [ADDR_W-1:0] SAVED_PC,
`ifdef INT_NEST_EN
    output logic [1:0]        NEST_DEPTH,
`endif
    output logic              IN_SERVICE
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_SRC-1:0]    r_hist;
    logic [N_SRC-1:0]    r_pend;
    logic [N_SRC-1:0]    r_mask;
    logic                r_gie;
    logic                r_take;
    logic [ADDR_W-1:0]   r_vec;
    logic [2:0]          r_id;
    logic [ADDR_W-1:0]   r_spc;
    logic                r_insvc;

    logic [N_SRC-1:0]    w_edge;
    logic [N_SRC-1:0]    w_elig;
    logic [N_SRC-1:0]    w_clr;
    logic                w_any;
    logic [2:0]          w_win;
    logic [ADDR_W-1:0]   w_vec;
    logic                w_take;
    logic                w_push;
    logic                w_pop;

`ifdef INT_NEST_EN
    logic [2:0]          r_stk_id [2];
    logic [ADDR_W-1:0]   r_stk_pc [2];
    logic [1:0]          r_sp;
`endif

    assign w_edge = IRQ_IN & ~r_hist;
    assign w_elig = r_pend & r_mask & {N_SRC{r_gie}};
    assign w_any  = |w_elig;
    assign w_vec  = VEC_BASE + ADDR_W'(32'(w_win) * 32'(VEC_STRIDE));

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end else if (WB_STROBE) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (RETI) begin
`ifdef INT_NEST_EN
                    if (r_sp != 2'd0) w_pop = 1'b1;
                    else              w_state_nxt = S_IDLE;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
`ifdef INT_NEST_EN
                else if (WB_STROBE && w_any && (w_win < r_id) && (r_sp == 2'd0)) begin
                    w_take = 1'b1;
                    w_push = 1'b1;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_clr = w_take ? (N_SRC'(1) << w_win) : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_hist  <= '1;
            r_pend  <= '0;
            r_mask  <= '0;
            r_gie   <= 1'b0;
            r_take  <= 1'b0;
            r_vec   <= '0;
            r_id    <= '0;
            r_spc   <= '0;
            r_insvc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= IRQ_IN;
            // A fresh edge on a bit being taken this cycle is kept.
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            r_take  <= w_take;
            r_insvc <= (w_state_nxt == S_SERVICE);
            if (MASK_WE) r_mask <= MASK_D;
            if (GIE_WE)  r_gie  <= GIE_D;
            if (w_take) begin
                r_id  <= w_win;
                r_vec <= w_vec;
                r_spc <= PC_IN;
            end
`ifdef INT_NEST_EN
            if (w_pop) begin
                r_id  <= r_stk_id[r_sp[0] - 1'b1];
                r_spc <= r_stk_pc[r_sp[0] - 1'b1];
            end
`endif
        end
    end

`ifdef INT_NEST_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sp        <= '0;
            r_stk_id[0] <= '0;
            r_stk_id[1] <= '0;
            r_stk_pc[0] <= '0;
            r_stk_pc[1] <= '0;
        end else if (w_push) begin
            r_stk_id[r_sp[0]] <= r_id;
            r_stk_pc[r_sp[0]] <= r_spc;
            r_sp              <= r_sp + 2'd1;
        end else if (w_pop) begin
            r_sp <= r_sp - 2'd1;
        end
    end

    assign NEST_DEPTH = r_sp + {1'b0, r_insvc};
`endif

    assign MASK       = r_mask;
    assign PENDING    = r_pend;
    assign INT_TAKE   = r_take;
    assign INT_VEC    = r_vec;
    assign INT_ID     = r_id;
    assign SAVED_PC   = r_spc;
    assign IN_SERVICE = r_insvc;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Prioritised interrupt controller for the 5-phase core.
- Collects 8 edge-triggered requests: 4 input-port, 4 timer.
- Holds pending and mask state, arbitrates by fixed priority, and redirects the PC to a vector at the writeback phase boundary.
- Saves the return PC and releases service on RETI.

Parameters:
- N_SRC, 8, number of interrupt sources (fixed-priority, index 0 highest).
- ADDR_W, 16, PC/vector width.
- VEC_BASE, 16'h0100, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- IRQ_IN  in  N_SRC  request lines; rising edge = event.
- WB_STROBE  in  1  one-cycle pulse marking the core writeback phase (CLKS[4] boundary).
- PC_IN  in  ADDR_W  PC of next instruction, valid with WB_STROBE.
- RETI  in  1  one-cycle pulse: core executed return-from-interrupt.
- GIE_WE  in  1  write global enable.
- GIE_D  in  1  global enable data.
- MASK_WE  in  1  write mask.
- MASK_D  in  N_SRC  mask data; 1 = enabled.
- MASK  out  N_SRC  current mask.
- PENDING  out  N_SRC  pending flags.
- INT_TAKE  out  1  one-cycle pulse: core must load INT_VEC into PC.
- INT_VEC  out  ADDR_W  vector address.
- INT_ID  out  3  id of source in service.
- SAVED_PC  out  ADDR_W  return address for RETI.
- IN_SERVICE  out  1  handler active.

Behaviour:
- Reset values (while RST_N=0 at a CLK edge):
  - PENDING=0, MASK=0, GIE=0, INT_TAKE=0, INT_VEC=0, INT_ID=0, SAVED_PC=0, IN_SERVICE=0, state=IDLE.
  - Edge-detect history = all ones, so a line already high at reset exit is not an event.
- Edge detect: IRQ_IN[i]=1 with history[i]=0 at a CLK edge sets PENDING[i], visible the next cycle. History is updated every cycle.
- PENDING bits are cleared only when taken. Masking never clears pending. A set and a clear of the same bit in the same cycle: set wins, so the new event is kept.
- ELIG = PENDING & MASK, qualified by GIE. WIN = lowest set index of ELIG.
- State machine:
  - IDLE -> REQ when ELIG != 0.
  - REQ -> IDLE when ELIG becomes 0 (mask or GIE write) before a strobe.
  - REQ with WB_STROBE=1, taken at that edge:
    - INT_TAKE=1 for exactly one cycle.
    - INT_ID=WIN; INT_VEC = VEC_BASE + WIN*VEC_STRIDE, truncated to ADDR_W.
    - SAVED_PC=PC_IN; PENDING[WIN] cleared; IN_SERVICE=1; state=SERVICE.
    - WIN is re-evaluated at the strobe edge, so a higher-priority event arriving during REQ wins.
  - SERVICE -> IDLE on RETI: IN_SERVICE=0. INT_ID, SAVED_PC and INT_VEC hold their values.
- RETI outside SERVICE is ignored.
- Minimum latency: edge sampled at edge k → PENDING at k → REQ at k+1 → INT_TAKE at the first WB_STROBE edge ≥ k+2.
- Without nesting, no new take occurs in SERVICE; events keep accumulating in PENDING.
- RETI and WB_STROBE with a new eligible source in the same cycle: go to IDLE. The next take needs a later strobe, so there is at most one take per core instruction.
- Reset mid-service: everything returns to reset values and any in-flight take is abandoned.
- Register writes:
  - MASK_WE and GIE_WE take effect at the edge and affect ELIG from the next cycle.
  - Simultaneous MASK_WE and take: arbitration uses the old mask.

Optional Feature:
INT_NEST_EN:
- Defined:
  - In SERVICE, an eligible source with index < current INT_ID is taken at WB_STROBE.
  - Current {INT_ID, SAVED_PC} is pushed onto a 2-entry stack; depth limit 2 active handlers.
  - A third level is not taken; it stays pending.
  - RETI pops the stack, restoring INT_ID/SAVED_PC, and stays in SERVICE. RETI with the stack empty → IDLE.
  - NEST_DEPTH (out, 2 bits) reports active handlers.
- Undefined: no preemption, no stack, no NEST_DEPTH port.

Test Plan:
1. Basic take:
   - Stimulus: reset, GIE=1, MASK=8'h01, rising IRQ_IN[0], WB_STROBE every 5 cycles with PC_IN=16'h0042.
   - Response: one INT_TAKE pulse, INT_VEC=16'h0100, SAVED_PC=16'h0042, PENDING=0, IN_SERVICE=1. RETI → IN_SERVICE=0.
2. Priority:
   - Stimulus: MASK=8'hFF, edges on IRQ_IN[5] and [2] in the same cycle.
   - Response: first take INT_ID=2, INT_VEC=16'h0108. After RETI, next take INT_ID=5, INT_VEC=16'h0114.
3. Masked hold:
   - Stimulus: MASK=0, edge on IRQ_IN[3].
   - Response: PENDING=8'h08, no INT_TAKE over 20 strobes. Then MASK=8'h08 → take at the next strobe ≥2 cycles later.
4. Withdraw in REQ:
   - Stimulus: enter REQ, write GIE=0 before the strobe.
   - Response: state IDLE, no INT_TAKE, PENDING retained.
5. Reset and edge-history rules:
   - Stimulus: IRQ_IN[1] held high through reset release.
   - Response: PENDING stays 0.
   - Stimulus: RST_N low during SERVICE.
   - Response: all outputs return to reset values.
6. Nesting (INT_NEST_EN):
   - Stimulus: in service of id 4 (SAVED_PC=16'h0010), take id 1 at PC 16'h0200.
   - Response: NEST_DEPTH=2. First RETI restores INT_ID=4 and SAVED_PC=16'h0010. Second RETI → IN_SERVICE=0.
